hazard_sb: RTL and testbench
============================

HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width; register file has 2**AW entries, and entry 0 is never written.
REQ-002 SHALL have parameter MAX_PEND, default 4: maximum number of outstanding long-latency writes (loads, divides); MAX_PEND >= 1.
REQ-003 SHALL have parameter WD_LIMIT, default 1023: stall-watchdog threshold in cycles.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports rsD, rtD, input, AW each: decode-stage source registers.
REQ-007 SHALL have ports rsE, rtE, writeregE, input, AW each: execute-stage sources and destination.
REQ-008 SHALL have ports regwriteE, longE, input, 1 each: E writes a register; E is a long-latency op.
REQ-009 SHALL have ports writeregM, writeregW, input, AW each, and regwriteM, regwriteW, hilo_writeM, hilo_writeW, input, 1 each.
REQ-010 SHALL have port longdoneW, input, 1: a long op is completing its writeback to writeregW this cycle.
REQ-011 SHALL have ports stall_divE, dmem_waitM, flush_exc, input, 1 each.
REQ-012 SHALL have ports forwardaE, forwardbE, forwardHiLoE, output, 2 each: 10 = forward from M, 01 = forward from W, 00 = use register file.
REQ-013 SHALL have ports stallF, stallD, stallE, stallM, stallW, flushE, output, 1 each.
REQ-014 SHALL have ports pend_cnt, output, clog2(MAX_PEND+1); and wd_timeout, output, 1.

Function
REQ-015 SHALL hold a pending bit per register (pend[1..2**AW-1]) and an outstanding counter cnt.
REQ-016 SHALL define issue = longE & regwriteE & (writeregE != 0) & ~stallE.
REQ-017 SHALL set pend[writeregE] and increment cnt on issue, registered.
REQ-018 SHALL clear pend[writeregW] and decrement cnt on longdoneW.
REQ-019 SHALL, on simultaneous issue and longdoneW, leave cnt unchanged; if both name the same register, the bit SHALL end set.
REQ-020 SHALL define rawstall = (rsD!=0 & pend[rsD] & ~(longdoneW & writeregW==rsD)) | the same term for rtD; clear bypass is same-cycle.
REQ-021 SHALL define fullstall = longE & regwriteE & (cnt == MAX_PEND) & ~longdoneW.
REQ-022 SHALL compute forwardaE/forwardbE: source 0 gives 00; M match with regwriteM gives 10 (priority); else W match with regwriteW gives 01; else 00.
REQ-023 SHALL compute forwardHiLoE: hilo_writeM gives 10; else hilo_writeW gives 01; else 00.
REQ-024 SHALL drive stallM = stallW = dmem_waitM.
REQ-025 SHALL drive stallE = stall_divE | fullstall | dmem_waitM.
REQ-026 SHALL drive stallF = stallD = rawstall | stallE.
REQ-027 SHALL drive flushE = (rawstall & ~stallE) | flush_exc.
REQ-028 SHALL, on flush_exc, clear all pend bits and set cnt to 0 next cycle, overriding issue and longdoneW; upstream suppresses longdoneW for killed ops.
REQ-029 SHALL ignore a decrement when cnt == 0 and SHALL never increment past MAX_PEND; each violation is an assertion failure in simulation.
REQ-030 SHALL drive pend_cnt = cnt; all outputs except pend_cnt and wd_timeout are combinational.

Reset
REQ-031 SHALL, while resetn = 0, clear all pend bits, set cnt = 0, clear the watchdog counter, and hold wd_timeout = 0.
REQ-032 SHALL have all outputs 0 with idle inputs immediately after reset.

Configuration
REQ-033 SHALL, when HAZARD_WATCHDOG_EN is defined, count consecutive cycles with stallF = 1, clear the count on any cycle with stallF = 0, and set wd_timeout sticky (cleared only by reset) when the count reaches WD_LIMIT.
REQ-034 SHALL, when HAZARD_WATCHDOG_EN is undefined, tie wd_timeout to 0 and instantiate no watchdog counter.

Verification
REQ-035 SHALL cover: load to r5 issued (longE, regwriteE, writeregE=5); next cycle rsD=5 -> stallD=1 and flushE=1 until the longdoneW cycle with writeregW=5, in which stallD=0.
REQ-036 SHALL cover: MAX_PEND=2, two loads outstanding, third longE -> stallE=1, pend_cnt=2; longdoneW in the same cycle -> stallE=0.
REQ-037 SHALL cover: rsE=3, writeregM=3, writeregW=3, both regwrite -> forwardaE=10; rsE=0 -> 00; hilo_writeM=hilo_writeW=1 -> forwardHiLoE=10.
REQ-038 SHALL cover: 3 pending, flush_exc pulse -> pend_cnt=0 and no RAW stall on any register next cycle.
REQ-039 SHALL cover: issue to r7 and longdoneW on r7 in the same cycle -> pend[7] still set and pend_cnt unchanged.
REQ-040 SHALL cover: with HAZARD_WATCHDOG_EN and WD_LIMIT=8, stall_divE held 8 cycles -> wd_timeout=1 and it stays 1 after the stall ends, until resetn=0.

Source files
------------

// File: rtl/hazard_sb.sv
// ---------------------------------------------------------------------------
// hazard_sb -- pipeline hazard unit with a long-latency write scoreboard.
//
// Tracks registers that have an outstanding long-latency write (loads,
// divides) and stalls decode while a younger instruction reads one of them.
// It also bounds the number of outstanding long writes, selects operand and
// HI/LO forwarding for execute, and generates the stall/flush controls for
// every pipeline stage.
//
// Parameters:
//   AW        register-address width (2**AW registers, r0 never written)
//   MAX_PEND  maximum outstanding long-latency writes (>= 1)
//   WD_LIMIT  consecutive stallF cycles before wd_timeout is raised
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   rsD, rtD                      decode-stage source registers
//   rsE, rtE, writeregE           execute-stage sources and destination
//   regwriteE, longE              E writes a register / E is a long op
//   writeregM/W, regwriteM/W      M and W destinations and write enables
//   hilo_writeM/W                 M and W write HI/LO
//   longdoneW                     long op writing back to writeregW now
//   stall_divE, dmem_waitM        divider busy / data memory wait
//   flush_exc                     exception flush, kills all pending ops
//   forwardaE/bE/HiLoE            10 = from M, 01 = from W, 00 = reg file
//   stallF/D/E/M/W, flushE        pipeline controls (combinational)
//   pend_cnt                      number of outstanding long writes
//   wd_timeout                    sticky stall-watchdog flag
//
// Optional feature: define HAZARD_WATCHDOG_EN to build the stall watchdog;
// without it wd_timeout is tied to 0 and no counter exists.
// ---------------------------------------------------------------------------
module hazard_sb #(
   parameter int AW       = 5,
   parameter int MAX_PEND = 4,
   parameter int WD_LIMIT = 1023
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [AW-1:0]                 rsD,
   input  logic [AW-1:0]                 rtD,
   input  logic [AW-1:0]                 rsE,
   input  logic [AW-1:0]                 rtE,
   input  logic [AW-1:0]                 writeregE,
   input  logic                          regwriteE,
   input  logic                          longE,
   input  logic [AW-1:0]                 writeregM,
   input  logic [AW-1:0]                 writeregW,
   input  logic                          regwriteM,
   input  logic                          regwriteW,
   input  logic                          hilo_writeM,
   input  logic                          hilo_writeW,
   input  logic                          longdoneW,
   input  logic                          stall_divE,
   input  logic                          dmem_waitM,
   input  logic                          flush_exc,
   output logic [1:0]                    forwardaE,
   output logic [1:0]                    forwardbE,
   output logic [1:0]                    forwardHiLoE,
   output logic                          stallF,
   output logic                          stallD,
   output logic                          stallE,
   output logic                          stallM,
   output logic                          stallW,
   output logic                          flushE,
   output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
   output logic                          wd_timeout
);

   localparam int NREG = 1 << AW;
   localparam int CW   = $clog2(MAX_PEND + 1);

   logic [NREG-1:0] pend;
   logic [CW-1:0]   cnt;
   logic            issue;
   logic            raw_rs;
   logic            raw_rt;
   logic            rawstall;
   logic            fullstall;

   // Operand forwarding: M has priority over W, r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                          input logic [AW-1:0] wr_m,
                                          input logic          rw_m,
                                          input logic [AW-1:0] wr_w,
                                          input logic          rw_w);
      if (src == '0)
         return 2'b00;
      else if (rw_m && (wr_m == src))
         return 2'b10;
      else if (rw_w && (wr_w == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign issue = longE & regwriteE & (writeregE != '0) & ~stallE;

   // A register whose long write completes this very cycle is readable
   // through the writeback bypass, so it does not stall decode.
   assign raw_rs = (rsD != '0) & pend[rsD] & ~(longdoneW & (writeregW == rsD));
   assign raw_rt = (rtD != '0) & pend[rtD] & ~(longdoneW & (writeregW == rtD));
   assign rawstall = raw_rs | raw_rt;

   // A completion in the same cycle frees a slot, so the new long op may go.
   assign fullstall = longE & regwriteE & (cnt == CW'(MAX_PEND)) & ~longdoneW;

   assign forwardaE    = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
   assign forwardbE    = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
   assign forwardHiLoE = hilo_writeM ? 2'b10 : (hilo_writeW ? 2'b01 : 2'b00);

   assign stallM   = dmem_waitM;
   assign stallW   = dmem_waitM;
   assign stallE   = stall_divE | fullstall | dmem_waitM;
   assign stallF   = rawstall | stallE;
   assign stallD   = rawstall | stallE;
   assign flushE   = (rawstall & ~stallE) | flush_exc;
   assign pend_cnt = cnt;

   // Scoreboard update. The set for a new issue is written after the clear
   // for a completion, so when both name the same register the bit stays
   // set. An exception flush discards everything in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend <= '0;
         cnt  <= '0;
      end else if (flush_exc) begin
         pend <= '0;
         cnt  <= '0;
      end else begin
         if (longdoneW)
            pend[writeregW] <= 1'b0;
         if (issue)
            pend[writeregE] <= 1'b1;
         if (issue && longdoneW)
            cnt <= cnt;
         else if (issue && (cnt != CW'(MAX_PEND)))
            cnt <= cnt + CW'(1);
         else if (longdoneW && (cnt != '0))
            cnt <= cnt - CW'(1);
      end
   end

   // Counter misuse checks: completion with nothing outstanding, or an
   // issue beyond capacity.
   a_no_underflow : assert property (@(posedge clk) disable iff (!resetn)
      !(longdoneW && !issue && !flush_exc && (cnt == '0)));
   a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
      !(issue && !longdoneW && !flush_exc && (cnt == CW'(MAX_PEND))));

`ifdef HAZARD_WATCHDOG_EN
   localparam int WW = $clog2(WD_LIMIT + 1);

   logic [WW-1:0] wd_cnt;

   // Stall watchdog: counts consecutive front-end stall cycles, saturating
   // at WD_LIMIT. The flag is raised on the cycle the count reaches the
   // limit and then held until reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_cnt     <= '0;
         wd_timeout <= 1'b0;
      end else if (stallF) begin
         if (wd_cnt != WW'(WD_LIMIT))
            wd_cnt <= wd_cnt + WW'(1);
         if (wd_cnt >= WW'(WD_LIMIT - 1))
            wd_timeout <= 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end
`else
   assign wd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// ---------------------------------------------------------------------------
// tb_hazard_sb -- self-checking bench for hazard_sb.
//
// Main instance: MAX_PEND=4, WD_LIMIT=8. A second instance with MAX_PEND=2
// shares most inputs but has private longE/longdoneW so only the capacity
// scenario drives its scoreboard. Inputs change on the falling edge and
// outputs are sampled 2 ns later, well clear of the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_sb;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic          regwriteE, longE, regwriteM, regwriteW;
   logic          hilo_writeM, hilo_writeW, longdoneW;
   logic          stall_divE, dmem_waitM, flush_exc;
   logic          longE2, longdoneW2;

   logic [1:0]    forwardaE, forwardbE, forwardHiLoE;
   logic          stallF, stallD, stallE, stallM, stallW, flushE;
   logic [2:0]    pend_cnt;
   logic          wd_timeout;

   logic [1:0]    forwardaE2, forwardbE2, forwardHiLoE2;
   logic          stallF2, stallD2, stallE2, stallM2, stallW2, flushE2;
   logic [1:0]    pend_cnt2;
   logic          wd_timeout2;

   int            tests = 0;
   int            failed = 0;

   typedef struct {
      logic [AW-1:0] rsE;
      logic [AW-1:0] rtE;
      logic [AW-1:0] wrM;
      logic [AW-1:0] wrW;
      logic          rwM;
      logic          rwW;
      logic          hiM;
      logic          hiW;
      logic          sdiv;
      logic          dwait;
      logic          fexc;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [1:0]    fhl;
      logic          sF;
      logic          sE;
      logic          sM;
      logic          fE;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   hazard_sb #(.AW(AW), .MAX_PEND(4), .WD_LIMIT(8)) dut (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .longE(longE),
      .writeregM(writeregM), .writeregW(writeregW),
      .regwriteM(regwriteM), .regwriteW(regwriteW),
      .hilo_writeM(hilo_writeM), .hilo_writeW(hilo_writeW),
      .longdoneW(longdoneW), .stall_divE(stall_divE), .dmem_waitM(dmem_waitM),
      .flush_exc(flush_exc),
      .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardHiLoE(forwardHiLoE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .stallW(stallW), .flushE(flushE), .pend_cnt(pend_cnt), .wd_timeout(wd_timeout)
   );

   hazard_sb #(.AW(AW), .MAX_PEND(2), .WD_LIMIT(1023)) dut2 (
      .clk(clk), .resetn(resetn),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
      .regwriteE(regwriteE), .longE(longE2),
      .writeregM(writeregM), .writeregW(writeregW),
      .regwriteM(regwriteM), .regwriteW(regwriteW),
      .hilo_writeM(hilo_writeM), .hilo_writeW(hilo_writeW),
      .longdoneW(longdoneW2), .stall_divE(stall_divE), .dmem_waitM(dmem_waitM),
      .flush_exc(flush_exc),
      .forwardaE(forwardaE2), .forwardbE(forwardbE2), .forwardHiLoE(forwardHiLoE2),
      .stallF(stallF2), .stallD(stallD2), .stallE(stallE2), .stallM(stallM2),
      .stallW(stallW2), .flushE(flushE2), .pend_cnt(pend_cnt2), .wd_timeout(wd_timeout2)
   );

   // Return every stimulus input to its idle value (reset untouched).
   task automatic applyIdle();
      rsD = '0; rtD = '0; rsE = '0; rtE = '0; writeregE = '0;
      writeregM = '0; writeregW = '0;
      regwriteE = 1'b0; longE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
      hilo_writeM = 1'b0; hilo_writeW = 1'b0; longdoneW = 1'b0;
      stall_divE = 1'b0; dmem_waitM = 1'b0; flush_exc = 1'b0;
      longE2 = 1'b0; longdoneW2 = 1'b0;
   endtask

   // Drive one table vector on top of an idle background.
   task automatic applyStimulus(input vec_t v);
      applyIdle();
      rsE = v.rsE; rtE = v.rtE; writeregM = v.wrM; writeregW = v.wrW;
      regwriteM = v.rwM; regwriteW = v.rwW;
      hilo_writeM = v.hiM; hilo_writeW = v.hiW;
      stall_divE = v.sdiv; dmem_waitM = v.dwait; flush_exc = v.fexc;
   endtask

   // One comparison: counts it and reports a failure line on mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic issueLong(input logic [AW-1:0] r);
      @(negedge clk);
      applyIdle();
      longE = 1'b1; regwriteE = 1'b1; writeregE = r;
   endtask

   initial begin
      // rsE rtE wrM wrW rwM rwW hiM hiW sdiv dwait fexc | fa fb fhl sF sE sM fE
      vecs[0] = '{5'd3,  5'd4, 5'd3,  5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{5'd0,  5'd3, 5'd3,  5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{5'd5,  5'd6, 5'd5,  5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{5'd7,  5'd7, 5'd2,  5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{5'd9,  5'd9, 5'd9,  5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5'd1,  5'd2, 5'd0,  5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{5'd1,  5'd2, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{5'd0,  5'd0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{5'd0,  5'd0, 5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{5'd31, 5'd1, 5'd31, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset state with idle inputs.
      applyIdle();
      resetn = 1'b0;
      #12;
      checkOutput("reset pend_cnt", pend_cnt, 0);
      checkOutput("reset stallF", stallF, 0);
      checkOutput("reset wd_timeout", wd_timeout, 0);
      @(negedge clk);
      resetn = 1'b1;
      #2;
      checkOutput("idle outputs", {forwardaE, forwardbE, forwardHiLoE, stallF, stallD,
                  stallE, stallM, stallW, flushE, pend_cnt, wd_timeout}, 0);

      // Combinational forwarding and stall vectors with an empty scoreboard.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("vec%0d forwardaE", i), forwardaE, vecs[i].fa);
         checkOutput($sformatf("vec%0d forwardbE", i), forwardbE, vecs[i].fb);
         checkOutput($sformatf("vec%0d forwardHiLoE", i), forwardHiLoE, vecs[i].fhl);
         checkOutput($sformatf("vec%0d stallF", i), stallF, vecs[i].sF);
         checkOutput($sformatf("vec%0d stallD", i), stallD, vecs[i].sF);
         checkOutput($sformatf("vec%0d stallE", i), stallE, vecs[i].sE);
         checkOutput($sformatf("vec%0d stallM", i), stallM, vecs[i].sM);
         checkOutput($sformatf("vec%0d stallW", i), stallW, vecs[i].sM);
         checkOutput($sformatf("vec%0d flushE", i), flushE, vecs[i].fE);
      end

      // Load to r5, then a dependent read stalls until the writeback cycle.
      issueLong(5'd5);
      #2;
      checkOutput("load r5 issue stallE", stallE, 0);
      @(negedge clk);
      applyIdle();
      rsD = 5'd5;
      #2;
      checkOutput("raw r5 pend_cnt", pend_cnt, 1);
      checkOutput("raw r5 stallD", stallD, 1);
      checkOutput("raw r5 flushE", flushE, 1);
      @(negedge clk);
      rsD = 5'd0; rtD = 5'd5;
      #2;
      checkOutput("raw r5 via rtD stallD", stallD, 1);
      checkOutput("raw r5 via rtD flushE", flushE, 1);
      @(negedge clk);
      rtD = 5'd0; rsD = 5'd5; stall_divE = 1'b1;
      #2;
      checkOutput("raw with stallE stallD", stallD, 1);
      checkOutput("raw with stallE flushE", flushE, 0);
      @(negedge clk);
      applyIdle();
      rsD = 5'd6;
      #2;
      checkOutput("other reg no stall", stallD, 0);
      @(negedge clk);
      rsD = 5'd5; longdoneW = 1'b1; writeregW = 5'd5;
      #2;
      checkOutput("r5 writeback bypass stallD", stallD, 0);
      checkOutput("r5 writeback bypass flushE", flushE, 0);
      @(negedge clk);
      applyIdle();
      rsD = 5'd5;
      #2;
      checkOutput("r5 cleared pend_cnt", pend_cnt, 0);
      checkOutput("r5 cleared stallD", stallD, 0);

      // Issue and completion on r7 in the same cycle.
      issueLong(5'd7);
      @(negedge clk);
      applyIdle();
      longE = 1'b1; regwriteE = 1'b1; writeregE = 5'd7;
      longdoneW = 1'b1; writeregW = 5'd7;
      #2;
      checkOutput("r7 same-cycle pend_cnt before", pend_cnt, 1);
      @(negedge clk);
      applyIdle();
      rsD = 5'd7;
      #2;
      checkOutput("r7 same-cycle pend_cnt after", pend_cnt, 1);
      checkOutput("r7 still pending stallD", stallD, 1);
      @(negedge clk);
      applyIdle();
      longdoneW = 1'b1; writeregW = 5'd7;
      @(negedge clk);
      applyIdle();
      rsD = 5'd7;
      #2;
      checkOutput("r7 drained pend_cnt", pend_cnt, 0);
      checkOutput("r7 drained stallD", stallD, 0);

      // Three pending loads killed by an exception flush, which also
      // overrides a simultaneous issue to r4.
      issueLong(5'd1);
      issueLong(5'd2);
      issueLong(5'd3);
      @(negedge clk);
      applyIdle();
      flush_exc = 1'b1;
      longE = 1'b1; regwriteE = 1'b1; writeregE = 5'd4;
      #2;
      checkOutput("three pending pend_cnt", pend_cnt, 3);
      checkOutput("flush_exc flushE", flushE, 1);
      @(negedge clk);
      applyIdle();
      #1;
      checkOutput("after flush pend_cnt", pend_cnt, 0);
      for (int r = 1; r <= 4; r++) begin
         rsD = AW'(r); rtD = AW'(r);
         #0.2;
         checkOutput($sformatf("after flush r%0d stallD", r), stallD, 0);
      end

      // Capacity limit on the MAX_PEND=2 instance.
      @(negedge clk);
      applyIdle();
      longE2 = 1'b1; regwriteE = 1'b1; writeregE = 5'd10;
      @(negedge clk);
      writeregE = 5'd11;
      @(negedge clk);
      writeregE = 5'd12;
      #2;
      checkOutput("full stallE", stallE2, 1);
      checkOutput("full stallF", stallF2, 1);
      checkOutput("full pend_cnt", pend_cnt2, 2);
      checkOutput("full main unaffected stallE", stallE, 0);
      @(negedge clk);
      #2;
      checkOutput("full held stallE", stallE2, 1);
      checkOutput("full held pend_cnt", pend_cnt2, 2);
      @(negedge clk);
      longdoneW2 = 1'b1; writeregW = 5'd10;
      #2;
      checkOutput("full with done stallE", stallE2, 0);
      @(negedge clk);
      applyIdle();
      rsD = 5'd12;
      #2;
      checkOutput("swap pend_cnt", pend_cnt2, 2);
      checkOutput("swap r12 pending stallD", stallD2, 1);
      rsD = 5'd10;
      #1;
      checkOutput("swap r10 released stallD", stallD2, 0);
      @(negedge clk);
      applyIdle();
      longdoneW2 = 1'b1; writeregW = 5'd11;
      @(negedge clk);
      writeregW = 5'd12;
      @(negedge clk);
      applyIdle();
      #2;
      checkOutput("drained pend_cnt", pend_cnt2, 0);

`ifdef HAZARD_WATCHDOG_EN
      // Eight consecutive stall cycles trip the watchdog; it then sticks.
      @(negedge clk);
      applyIdle();
      stall_divE = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         #2;
         checkOutput($sformatf("watchdog after %0d stall cycles", i), wd_timeout, (i >= 8) ? 1 : 0);
      end
      @(negedge clk);
      stall_divE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         checkOutput("watchdog sticky", wd_timeout, 1);
      end
      resetn = 1'b0;
      #1;
      checkOutput("watchdog cleared by reset", wd_timeout, 0);
      @(negedge clk);
      resetn = 1'b1;
`else
      // Without the watchdog the flag never rises, however long the stall.
      @(negedge clk);
      applyIdle();
      stall_divE = 1'b1;
      repeat (12) @(negedge clk);
      #2;
      checkOutput("watchdog absent", wd_timeout, 0);
      stall_divE = 1'b0;
`endif

      // Short stalls separated by a free cycle never reach the limit.
      @(negedge clk);
      applyIdle();
      repeat (2) begin
         stall_divE = 1'b1;
         repeat (5) @(negedge clk);
         stall_divE = 1'b0;
         @(negedge clk);
      end
      #2;
      checkOutput("watchdog restarts on free cycle", wd_timeout, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
